// File: rtl/spi_pkg.sv
// Shared types and constants for the byte-wide SPI initiator.
package spi_pkg;
    localparam int SPI_BYTE_W      = 8;
    localparam int SPI_CLK_DIV_MIN = 2;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        TRAIL
    } spi_state_e;
endpackage

// File: rtl/spi_half_period_cnt.sv
// Loadable down-counter; tc is high once the loaded count has fully elapsed.
module spi_half_period_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);
endmodule

// File: rtl/spi_master.sv
// Mode-0, LSB-first, 8-bit SPI initiator with optional chip-select hold
// across bytes. spi_clk, cs_n and mosi are all driven straight from flops.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int LEAD_CYC  = CLK_DIV,
    parameter int TRAIL_CYC = CLK_DIV
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [SPI_BYTE_W-1:0] tx_byte,
    input  logic                  cs_hold,
    output logic                  busy,
    output logic [SPI_BYTE_W-1:0] rx_byte,
    output logic                  rx_valid,
    output logic                  spi_clk,
    output logic                  cs_n,
    output logic                  mosi,
    input  logic                  miso
);
    localparam int MAX_A   = (CLK_DIV > LEAD_CYC) ? CLK_DIV : LEAD_CYC;
    localparam int MAX_CYC = (MAX_A > TRAIL_CYC) ? MAX_A : TRAIL_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC);
    localparam int IDX_W   = $clog2(SPI_BYTE_W);

    localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LEAD_LD  = CNT_W'(LEAD_CYC - 1);
    localparam logic [CNT_W-1:0] TRAIL_LD = CNT_W'(TRAIL_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(SPI_BYTE_W - 1);

    if (CLK_DIV < SPI_CLK_DIV_MIN) begin : g_bad_clk_div
        $error("spi_master: CLK_DIV must be at least %0d", SPI_CLK_DIV_MIN);
    end
    if (LEAD_CYC < 1 || TRAIL_CYC < 1) begin : g_bad_lead_trail
        $error("spi_master: LEAD_CYC and TRAIL_CYC must be at least 1");
    end

    spi_state_e            state_q, state_d;
    logic                  pend_q, pend_d;
    logic                  hold_q, hold_d;
    logic [SPI_BYTE_W-1:0] tx_sh_q, tx_sh_d;
    logic [SPI_BYTE_W-1:0] rx_sh_q, rx_sh_d;
    logic [SPI_BYTE_W-1:0] rx_byte_q, rx_byte_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic [IDX_W-1:0]      bit_idx_inc;
    logic                  rx_valid_q, rx_valid_d;
    logic                  busy_q, busy_d;
    logic                  spi_clk_q, spi_clk_d;
    logic                  cs_n_q, cs_n_d;
    logic                  mosi_q, mosi_d;
    logic                  miso_s1_q, miso_s2_q;
    logic                  cnt_load;
    logic [CNT_W-1:0]      cnt_load_val;
    logic                  cnt_tc;

    spi_half_period_cnt #(.W(CNT_W)) u_half_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .tc       (cnt_tc)
    );

    assign bit_idx_inc = bit_idx_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        hold_d       = hold_q;
        tx_sh_d      = tx_sh_q;
        rx_sh_d      = rx_sh_q;
        rx_byte_d    = rx_byte_q;
        bit_idx_d    = bit_idx_q;
        rx_valid_d   = 1'b0;
        busy_d       = busy_q;
        spi_clk_d    = spi_clk_q;
        cs_n_d       = cs_n_q;
        mosi_d       = mosi_q;
        cnt_load     = 1'b0;
        cnt_load_val = DIV_LD;
        unique case (state_q)
            IDLE: begin
                // Capture on the accepting edge, launch the frame one edge later.
                if (pend_q) begin
                    pend_d       = 1'b0;
                    state_d      = LEAD;
                    cs_n_d       = 1'b0;
                    busy_d       = 1'b1;
                    mosi_d       = tx_sh_q[0];
                    cnt_load     = 1'b1;
                    cnt_load_val = LEAD_LD;
                end else if (start) begin
                    pend_d    = 1'b1;
                    tx_sh_d   = tx_byte;
                    hold_d    = cs_hold;
                    bit_idx_d = '0;
                end
            end
            LEAD, LOW: begin
                if (cnt_tc) begin
                    state_d   = HIGH;
                    spi_clk_d = 1'b1;
                    cnt_load  = 1'b1;
                end
            end
            HIGH: begin
                if (cnt_tc) begin
                    rx_sh_d[bit_idx_q] = miso_s2_q;
                    spi_clk_d          = 1'b0;
                    cnt_load           = 1'b1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d      = TRAIL;
                        cnt_load_val = TRAIL_LD;
                        rx_byte_d    = {miso_s2_q, rx_sh_q[SPI_BYTE_W-2:0]};
                        rx_valid_d   = 1'b1;
                    end else begin
                        state_d   = LOW;
                        bit_idx_d = bit_idx_inc;
                        mosi_d    = tx_sh_q[bit_idx_inc];
                    end
                end
            end
            TRAIL: begin
                if (cnt_tc) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cs_n_d  = ~hold_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            hold_q     <= 1'b0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_byte_q  <= '0;
            bit_idx_q  <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            spi_clk_q  <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            miso_s1_q  <= 1'b0;
            miso_s2_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            hold_q     <= hold_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_byte_q  <= rx_byte_d;
            bit_idx_q  <= bit_idx_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            spi_clk_q  <= spi_clk_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            miso_s1_q  <= miso;
            miso_s2_q  <= miso_s1_q;
        end
    end

    assign busy     = busy_q;
    assign rx_byte  = rx_byte_q;
    assign rx_valid = rx_valid_q;
    assign spi_clk  = spi_clk_q;
    assign cs_n     = cs_n_q;
    assign mosi     = mosi_q;
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV=4 and CLK_DIV=2), loopback or
// a falling-edge responder model on miso, timing checked against edge arithmetic.
module tb_spi_master;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_r = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       cs_hold = 1'b0;
    logic       loopback = 1'b1;
    logic [7:0] resp_byte = 8'h00;
    int         fall_cnt = 0;
    int         resp_base = 0;
    logic       cs_idle_exp [2];

    int n_checks = 0;
    int n_fail   = 0;

    logic       start_a, busy_a, rx_valid_a, spi_clk_a, cs_n_a, mosi_a, miso_a;
    logic       start_b, busy_b, rx_valid_b, spi_clk_b, cs_n_b, mosi_b, miso_b;
    logic [7:0] rx_byte_a, rx_byte_b;
    logic       v_busy, v_rx_valid, v_sclk, v_cs_n, v_mosi, resp_bit;
    logic [7:0] v_rx_byte;

    always #5 clk = ~clk;

    assign start_a    = start_r & ~sel;
    assign start_b    = start_r & sel;
    assign resp_bit   = resp_byte[3'(fall_cnt - resp_base)];
    assign miso_a     = loopback ? mosi_a : resp_bit;
    assign miso_b     = loopback ? mosi_b : resp_bit;
    assign v_busy     = sel ? busy_b : busy_a;
    assign v_rx_valid = sel ? rx_valid_b : rx_valid_a;
    assign v_rx_byte  = sel ? rx_byte_b : rx_byte_a;
    assign v_sclk     = sel ? spi_clk_b : spi_clk_a;
    assign v_cs_n     = sel ? cs_n_b : cs_n_a;
    assign v_mosi     = sel ? mosi_b : mosi_a;

    // Responder shifts out its next bit on every spi_clk falling edge.
    always @(negedge v_sclk) fall_cnt <= fall_cnt + 1;

    spi_master #(.CLK_DIV(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .tx_byte(tx_byte),
        .cs_hold(cs_hold), .busy(busy_a), .rx_byte(rx_byte_a),
        .rx_valid(rx_valid_a), .spi_clk(spi_clk_a), .cs_n(cs_n_a),
        .mosi(mosi_a), .miso(miso_a)
    );

    spi_master #(.CLK_DIV(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .tx_byte(tx_byte),
        .cs_hold(cs_hold), .busy(busy_b), .rx_byte(rx_byte_b),
        .rx_valid(rx_valid_b), .spi_clk(spi_clk_b), .cs_n(cs_n_b),
        .mosi(mosi_b), .miso(miso_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One byte on the selected instance; expected timing from the edge formulas.
    task automatic run_byte(input logic [7:0] tx, input logic hold, input logic [7:0] resp,
                            input logic loop, input logic poke);
        int         div, rises, nval, vedge, bfall, hi_cyc;
        logic       prev_sclk, cs_bad;
        logic [7:0] mosi_seen, rx_got, exp_rx;
        div       = sel ? 2 : 4;
        exp_rx    = loop ? tx : resp;
        tx_byte   = tx;
        cs_hold   = hold;
        resp_byte = resp;
        loopback  = loop;
        resp_base = fall_cnt;
        start_r   = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0;
        tx_byte = 8'($urandom);
        cs_hold = 1'($urandom);
        check_eq("busy_edge0", 32'(v_busy), 32'd0);
        check_eq("cs_n_edge0", 32'(v_cs_n), 32'(cs_idle_exp[sel]));
        rises = 0; nval = 0; vedge = -1; bfall = -1; hi_cyc = 0;
        prev_sclk = v_sclk; cs_bad = 1'b0; mosi_seen = 8'h00; rx_got = 8'h00;
        for (int e = 1; e <= 300 && bfall < 0; e++) begin
            start_r = poke && (e == 10 || e == 30);
            if (start_r) tx_byte = 8'($urandom);
            @(posedge clk); #1;
            if (e == 1) begin
                check_eq("busy_edge1", 32'(v_busy), 32'd1);
                check_eq("cs_n_edge1", 32'(v_cs_n), 32'd0);
                check_eq("mosi_edge1", 32'(v_mosi), 32'(tx[0]));
            end
            if (v_sclk) hi_cyc++;
            if (v_sclk && !prev_sclk) begin
                if (rises < 8) mosi_seen[rises[2:0]] = v_mosi;
                if (rises == 0) check_eq("first_rise_edge", e, 1 + div);
                rises++;
            end
            prev_sclk = v_sclk;
            if (v_rx_valid) begin
                nval++;
                vedge  = e;
                rx_got = v_rx_byte;
            end
            if (!v_busy) begin
                bfall = e;
                check_eq("cs_n_end", 32'(v_cs_n), 32'(!hold));
            end else if (v_cs_n) begin
                cs_bad = 1'b1;
            end
        end
        start_r = 1'b0;
        check_eq("sclk_rises", rises, 8);
        check_eq("mosi_bits", 32'(mosi_seen), 32'(tx));
        check_eq("rx_valid_count", nval, 1);
        check_eq("rx_valid_edge", vedge, 1 + div + 15 * div);
        check_eq("rx_byte", 32'(rx_got), 32'(exp_rx));
        check_eq("busy_fall_edge", bfall, 1 + div + 15 * div + div);
        check_eq("sclk_high_cycles", hi_cyc, 8 * div);
        check_eq("cs_n_low_busy", 32'(cs_bad), 32'd0);
        check_eq("rx_byte_hold", 32'(v_rx_byte), 32'(exp_rx));
        cs_idle_exp[sel] = !hold;
        $display("txn div=%0d tx=%02h hold=%0d loop=%0d poke=%0d rx=%02h valid@%0d busy_low@%0d",
                 div, tx, hold, loop, poke, rx_got, vedge, bfall);
    endtask

    initial begin
        logic seen_v;
        cs_idle_exp[0] = 1'b1;
        cs_idle_exp[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_spi_clk", 32'(spi_clk_a), 32'd0);
        check_eq("rst_cs_n", 32'(cs_n_a), 32'd1);
        check_eq("rst_mosi", 32'(mosi_a), 32'd0);
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        check_eq("rst_rx_valid", 32'(rx_valid_a), 32'd0);
        check_eq("rst_rx_byte", 32'(rx_byte_a), 32'd0);
        check_eq("rst_cs_n_b", 32'(cs_n_b), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        sel = 1'b0;
        run_byte(8'hA5, 1'b0, 8'h00, 1'b1, 1'b0);
        run_byte(8'hC3, 1'b0, 8'h3C, 1'b0, 1'b0);
        run_byte(8'h01, 1'b1, 8'h5E, 1'b1, 1'b0);
        run_byte(8'h02, 1'b0, 8'h77, 1'b1, 1'b0);
        run_byte(8'h96, 1'b0, 8'h00, 1'b1, 1'b1);

        // Reset mid-byte: outputs drop without a clock edge, no stray rx_valid.
        tx_byte = 8'h5A; cs_hold = 1'b0; loopback = 1'b1; start_r = 1'b1;
        @(posedge clk); #1;
        start_r = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_spi_clk", 32'(spi_clk_a), 32'd0);
        check_eq("arst_cs_n", 32'(cs_n_a), 32'd1);
        check_eq("arst_busy", 32'(busy_a), 32'd0);
        check_eq("arst_rx_valid", 32'(rx_valid_a), 32'd0);
        seen_v = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rx_valid_a) seen_v = 1'b1;
        end
        rst_n = 1'b1;
        repeat (80) begin
            @(posedge clk); #1;
            if (rx_valid_a) seen_v = 1'b1;
        end
        check_eq("arst_no_rx_valid", 32'(seen_v), 32'd0);
        cs_idle_exp[0] = 1'b1;
        cs_idle_exp[1] = 1'b1;
        run_byte(8'h3B, 1'b0, 8'h00, 1'b1, 1'b0);

        sel = 1'b1;
        run_byte(8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
        run_byte(8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);
        run_byte(8'hFF, 1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 10; i++) begin
            sel = 1'($urandom);
            run_byte(8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end
        sel = 1'b0;
        run_byte(8'h81, 1'b0, 8'h42, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Byte-wide SPI initiator. It pairs with the cartridge's SPI responder and drives the spi_clk / mosi / cs_n link from the system clock domain.
- Mode 0 (CPOL=0, CPHA=0), LSB first, 8-bit frames. spi_clk is generated by dividing clk.
- Optional chip-select hold lets several bytes be sent as one multi-byte transaction.

Parameters:
- CLK_DIV, 4: clk cycles per spi_clk half-period. Must be >= 2; an elaboration-time check fails otherwise.
- LEAD_CYC, CLK_DIV: clk cycles from cs_n falling to the first spi_clk rising edge.
- TRAIL_CYC, CLK_DIV: clk cycles after the last spi_clk falling edge before busy drops.

Ports:
- clk  in  1  system clock; all logic is on posedge clk.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle request; sampled only when busy=0.
- tx_byte  in  8  byte to transmit; captured on the start-sampling edge.
- cs_hold  in  1  captured with start; 1 keeps cs_n low after this byte.
- busy  out  1  high from the cycle after start acceptance until the end of TRAIL.
- rx_byte  out  8  last received byte; holds its value until the next rx_valid.
- rx_valid  out  1  one-cycle pulse; rx_byte is valid in the same cycle.
- spi_clk  out  1  serial clock, registered, idles low.
- cs_n  out  1  chip select, registered, active-low.
- mosi  out  1  serial data out, registered.
- miso  in  1  serial data in; passed through a 2-flop synchronizer before use.

Behaviour:
- Reset (async assert, synchronous release):
  - Outputs: spi_clk=0, cs_n=1, mosi=0, busy=0, rx_valid=0, rx_byte=8'h00.
  - Internal: state=IDLE, shift registers and counters cleared.
  - Reset mid-transfer aborts immediately. There is no partial rx_valid.
- FSM states: IDLE, LEAD, HIGH, LOW, TRAIL.
  - A half-period counter div_cnt runs 0..N-1 in each timed state. The transition happens on the edge where div_cnt=N-1.
- IDLE:
  - start=1 on an edge: latch tx_byte into tx_sh, latch cs_hold, set bit_idx=0.
  - Next cycle: cs_n=0, mosi=tx_byte[0], busy=1, state=LEAD.
  - start while busy=1 is ignored. No queuing.
- LEAD: spi_clk=0 for LEAD_CYC cycles, then HIGH.
- HIGH:
  - spi_clk=1 for CLK_DIV cycles.
  - On the final edge, sample synchronized miso into rx_sh[bit_idx]. Then spi_clk=0.
  - If bit_idx=7, go to TRAIL. Otherwise go to LOW and increment bit_idx.
- LOW:
  - On entry, mosi=tx_sh[bit_idx], so it changes with spi_clk falling.
  - spi_clk=0 for CLK_DIV cycles, then HIGH.
- End of byte:
  - On the edge leaving HIGH with bit_idx=7: rx_byte<=rx_sh with bit 7 included, and rx_valid=1 for exactly one cycle.
- TRAIL:
  - TRAIL_CYC cycles, mosi holds bit 7.
  - On exit: busy=0, state=IDLE. If cs_hold=0, cs_n=1 on the same edge; if cs_hold=1, cs_n stays 0.
- Held chip select:
  - A new start in IDLE with cs_n already 0 skips nothing. LEAD still runs, so timing is uniform.
  - When cs_hold=1, cs_n returns to 1 only after a later byte completes with cs_hold=0, or on reset.
- Timing with defaults (CLK_DIV=4), counting the start-sampling edge as edge 0:
  - busy/cs_n assert at edge 1.
  - First spi_clk rise at edge 1+4.
  - rx_valid at edge 1+4+15*4 = 65.
  - busy low at edge 69.
  - General rule: rx_valid at 1+LEAD_CYC+15*CLK_DIV; busy low TRAIL_CYC later.
- spi_clk has exactly 8 rising edges per byte and a 50% duty cycle within the byte.
- miso is sampled at the late end of the high phase, which tolerates responder output changes on the falling edge plus synchronizer delay.

Decomposition:
- Package spi_pkg: state enum (IDLE, LEAD, HIGH, LOW, TRAIL), SPI_BYTE_W=8, and the CLK_DIV minimum constant.
- One sub-module, spi_half_period_cnt: loadable down-counter with a terminal-count flag, reused for the LEAD, HIGH, LOW and TRAIL timing.
- Shift registers, the miso synchronizer and the FSM stay in spi_master.

Test Plan:
- Loopback (mosi tied to miso, CLK_DIV=4), start with tx_byte=8'hA5 -> 8 spi_clk rises, mosi bit order 1,0,1,0,0,1,0,1, rx_valid at edge 65 with rx_byte=8'hA5, busy low at edge 69, cs_n high at edge 69.
- Behavioural responder model returns 8'h3C while tx_byte=8'hC3 -> rx_byte=8'h3C; mosi observed at each spi_clk rise equals 8'hC3 LSB first.
- Two bytes, the first with cs_hold=1 (8'h01) and the second with cs_hold=0 (8'h02) -> cs_n never deasserts between bytes, two rx_valid pulses, cs_n=1 after the second TRAIL.
- start pulsed at edges 10 and 30 during a transfer -> ignored; exactly one rx_valid; tx shift contents unchanged.
- rst_n asserted at edge 40 mid-byte -> spi_clk=0, cs_n=1, busy=0 asynchronously; no rx_valid; a new start after release completes normally.
- CLK_DIV=2 with 8'hFF/8'h00 patterns -> spi_clk period 4 clk cycles, rx_valid at edge 1+2+30=33.
